// File: rtl/blake512_nonce_scan_if.sv
// Signal bundle between the nonce scanner, its controller and the downstream blake512 hasher.
// The slave modport is the scanner's view; master is the controller/hasher side.
interface blake512_nonce_scan_if;
  logic         start;
  logic         abort;
  logic [639:0] header_in;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [255:0] target_in;
  logic         new_out;
  logic [639:0] data_out;
  logic [511:0] hash_in;
  logic         hash_done;
  logic         busy;
  logic         found;
  logic [31:0]  found_nonce;
  logic         done;
  logic         error;
  logic [31:0]  hash_count;

  modport slave (
    input  start, abort, header_in, nonce_start, nonce_end, target_in, hash_in, hash_done,
    output new_out, data_out, busy, found, found_nonce, done, error, hash_count
  );

  modport master (
    output start, abort, header_in, nonce_start, nonce_end, target_in, hash_in, hash_done,
    input  new_out, data_out, busy, found, found_nonce, done, error, hash_count
  );
endinterface

// File: rtl/blake512_nonce_scan.sv
// Walks a nonce range, issuing one blake512 job per nonce and comparing each digest's
// upper 256 bits against a target. Handshake: new_out pulses once per job; the hasher answers
// with a one-cycle hash_done (hash_in valid that cycle) no earlier than the cycle after new_out.
module blake512_nonce_scan #(
  parameter bit STOP_ON_FIND = 1'b1,
  parameter int TIMEOUT      = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  blake512_nonce_scan_if.slave        bus,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state, state_nxt;
  logic [607:0]   hdr_q;
  logic [31:0]    nonce_q;
  logic [31:0]    end_q;
  logic [255:0]   tgt_q;
  logic [255:0]   cap_q;
  logic [TW-1:0]  tmo_q;
  logic           hit;
  logic           new_d, busy_d, found_d, done_d, error_d;
  logic           unused_bits;

  // The nonce field of the template and the lower digest half never influence the scan.
  assign unused_bits = ^{bus.header_in[31:0], bus.hash_in[255:0]};

  assign hit          = (cap_q <= tgt_q);
  assign bus.data_out = {hdr_q, nonce_q};
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    found_d   = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.hash_done) begin
          state_nxt = CHECK;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          error_d   = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        found_d = hit;
        if ((hit && STOP_ON_FIND) || (nonce_q == end_q)) begin
          done_d    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything, including a hit decided in this same CHECK cycle.
    if (bus.abort) begin
      state_nxt = IDLE;
      found_d   = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b0;
    end
    new_d  = (state_nxt == ISSUE);
    busy_d = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.new_out     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.found       <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.found_nonce <= '0;
      bus.hash_count  <= '0;
      hdr_q           <= '0;
      nonce_q         <= '0;
      end_q           <= '0;
      tgt_q           <= '0;
      cap_q           <= '0;
      tmo_q           <= '0;
    end else begin
      bus.new_out <= new_d;
      bus.busy    <= busy_d;
      bus.found   <= found_d;
      bus.done    <= done_d;
      bus.error   <= error_d;
      if (found_d) bus.found_nonce <= nonce_q;

      if (state == IDLE && bus.start && !bus.abort) begin
        hdr_q          <= bus.header_in[639:32];
        nonce_q        <= bus.nonce_start;
        end_q          <= bus.nonce_end;
        tgt_q          <= bus.target_in;
        bus.hash_count <= '0;
      end else if (state == CHECK && !bus.abort) begin
        bus.hash_count <= bus.hash_count + 32'd1;
        if (state_nxt == ISSUE) nonce_q <= nonce_q + 32'd1;
      end

      // Cleared while issuing so the first WAIT cycle reads zero.
      if (state == ISSUE)
        tmo_q <= '0;
      else if (state == WAIT && tmo_q != TW'(TIMEOUT))
        tmo_q <= tmo_q + 1'b1;

      if (state == WAIT && bus.hash_done) cap_q <= bus.hash_in[511:256];
    end
  end

endmodule

// File: doc/blake512_nonce_scan.md
# blake512_nonce_scan

Upstream work driver for `blake512_hash`. It latches an 80-byte header template, a nonce range and a 256-bit target. It then issues one hash job per nonce, holding `data_in` and pulsing `new_in`, and waits for each result. Each 512-bit digest is compared against the target, and the block reports the first hit (or all hits), range completion, or a stalled hasher.

## Interface
Parameters:
- `STOP_ON_FIND`, 1: 1 = end scan at first hit; 0 = report every hit and continue to `nonce_end`.
- `TIMEOUT`, 1024: max cycles spent in WAIT before `error` (≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, active-high, asynchronous assert.
- `start`  in  1  pulse; in IDLE latches `header_in`, `nonce_start`, `nonce_end`, `target_in`.
- `abort`  in  1  synchronous abort to IDLE.
- `header_in`  in  640  header template; bits [31:0] ignored (nonce field).
- `nonce_start`  in  32  first nonce.
- `nonce_end`  in  32  last nonce, inclusive.
- `target_in`  in  256  hit when `hash_in[511:256]` ≤ target (unsigned).
- `new_out`  out  1  to hasher `new_in`.
- `data_out`  out  640  to hasher `data_in`: {header[639:32], nonce}.
- `hash_in`  in  512  from hasher `hash_out`.
- `hash_done`  in  1  one-cycle pulse; `hash_in` valid that cycle.
- `busy`  out  1  high in any state except IDLE.
- `found`  out  1  one-cycle pulse per hit.
- `found_nonce`  out  32  nonce of most recent hit; held.
- `done`  out  1  one-cycle pulse at scan end (range exhausted or stop-on-find).
- `error`  out  1  one-cycle pulse on WAIT timeout.
- `hash_count`  out  32  hashes checked since last `start`; wraps mod 2^32.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK.
- IDLE:
  - `start`=1 (and `abort`=0) → latch inputs, nonce←`nonce_start`, `hash_count`←0, go to ISSUE.
  - `hash_done` is ignored.
- ISSUE:
  - `new_out`=1 for exactly this cycle.
  - `data_out` is updated with the current nonce on entry and held unchanged until the next ISSUE.
  - Always goes to WAIT.
- WAIT:
  - Timeout counter cleared on entry.
  - `hash_done`=1 → capture `hash_in` into a register, go to CHECK.
  - Counter reaches `TIMEOUT` → `error` pulse, go to IDLE (no `done`).
- CHECK:
  - `hash_count`+1.
  - hit = captured[511:256] ≤ target.
  - On hit: `found` pulse, `found_nonce`←nonce.
  - If (hit and `STOP_ON_FIND`) or nonce == `nonce_end` → `done` pulse, go to IDLE.
  - Otherwise nonce←nonce+1 mod 2^32, go to ISSUE.
- Wrap-around: `nonce_end` < `nonce_start` scans through 0xFFFFFFFF → 0. The scan terminates only on equality with `nonce_end`. `nonce_start` == `nonce_end` scans exactly one nonce.
- `abort`:
  - Any state → IDLE on the next edge.
  - No `found`/`done`/`error` is generated, and a `found` pending from the same-cycle CHECK is suppressed.
  - `abort` beats `start` when both are high in IDLE.
- `start` outside IDLE is ignored.
- `hash_done` in ISSUE is ignored; the hasher must pulse it in a cycle after `new_out`.
- Reset (any time, including mid-scan):
  - State IDLE.
  - `new_out`, `busy`, `found`, `done`, `error` = 0.
  - `data_out`, `found_nonce`, `hash_count`, all latched registers = 0.
  - The hasher is not reset by this block; its late `hash_done` lands in IDLE and is ignored.

## Timing
- All outputs are registered. `found`, `done` and `error` are driven in the cycle after the deciding state.
- `start` sampled at edge 0 → `busy`=1 and `new_out`=1 in cycle 1.
- `new_out` in cycle t, `hash_done` in cycle t+L (L≥1):
  - CHECK is at t+L+1.
  - `found`/`done` are high at t+L+2.
  - The next `new_out` is also at t+L+2, so the per-nonce period is L+2 cycles.
- `busy` falls in the same cycle `done`/`error` is high, or the cycle after `abort` is sampled.
- Timeout: `error` is high `TIMEOUT`+1 cycles after WAIT entry when no `hash_done` arrives.

## Test plan
Bench hasher stub: fixed latency L=5; returns `hash_in` = {nonce, 480'h0}. Unless stated, `target_in` = {32'h00000010, 224'h0} and `STOP_ON_FIND`=1.
- **No hit**: range 0x20..0x25 → six `new_out` pulses 7 cycles apart, `data_out[31:0]` = 0x20..0x25, `data_out[639:32]` = header; `done` with no `found`; `hash_count`=6.
- **Wrap plus first hit**: range 0xFFFFFFFE..0x3 → nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x0 issued; `found` and `done` in the same cycle; `found_nonce`=0; `hash_count`=3; nonce 0x1 never issued.
- **Continue mode** (`STOP_ON_FIND`=0): range 0x0F..0x12 → `found` for 0x0F and 0x10; `done` after 0x12; `found_nonce`=0x10; `hash_count`=4.
- **Single nonce**: `nonce_start`=`nonce_end`=0x10 → one `new_out`; `found`+`done`; `hash_count`=1.
- **Abort**: `abort` 2 cycles into WAIT → `busy`=0 next cycle, no further `new_out`; the stub's late `hash_done` produces no `found`/`done`; `start` in the same cycle as `abort` is ignored.
- **Timeout and reset**: stub never pulses `hash_done`, `TIMEOUT`=16 → `error` 17 cycles after WAIT entry, no `done`. Then `rst` asserted mid-WAIT of a new scan → all outputs 0 immediately.
